// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared encodings for the hazard scoreboard: forwarding selects, jump type and MD tracker states.
// The optional stall statistics are enabled with the STALL_STATS_EN macro.
package hazard_scoreboard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] JUMP_JR = 2'b10;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    // Counter width for the MD countdown; never narrower than one bit.
    function automatic int md_cnt_width(input int latency);
        return (latency < 2) ? 1 : $clog2(latency);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-to-hazard-unit bundle: register numbers and stage controls in, stalls/flushes/selects out.
// The pipeline side uses the master modport, the hazard unit the slave modport.
interface hazard_scoreboard_unit_if #(parameter int REG_ADDR_W = 5);

    logic [1:0]            sig_jump_d;
    logic                  sig_branch_d;
    logic                  branch_taken_d;
    logic                  sig_md_op_d;
    logic [REG_ADDR_W-1:0] rs_d, rt_d, rs_e, rt_e;
    logic [REG_ADDR_W-1:0] write_reg_e, write_reg_m, write_reg_w;
    logic                  sig_reg_write_e, sig_reg_write_m, sig_reg_write_w;
    logic                  sig_mem_to_reg_e, sig_mem_to_reg_m;
    logic                  sig_md_start_e;
    logic [REG_ADDR_W-1:0] md_dest_e;

    logic                  stall_f, stall_d, flush_d, flush_e;
    logic                  forward_a_d, forward_b_d;
    logic [1:0]            forward_a_e, forward_b_e;
    logic                  md_busy, md_wb_valid, md_overrun;
    logic [REG_ADDR_W-1:0] md_wb_reg;

    modport master (
        output sig_jump_d, sig_branch_d, branch_taken_d, sig_md_op_d,
               rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               sig_reg_write_e, sig_reg_write_m, sig_reg_write_w,
               sig_mem_to_reg_e, sig_mem_to_reg_m, sig_md_start_e, md_dest_e,
        input  stall_f, stall_d, flush_d, flush_e, forward_a_d, forward_b_d,
               forward_a_e, forward_b_e, md_busy, md_wb_valid, md_overrun, md_wb_reg
    );

    modport slave (
        input  sig_jump_d, sig_branch_d, branch_taken_d, sig_md_op_d,
               rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               sig_reg_write_e, sig_reg_write_m, sig_reg_write_w,
               sig_mem_to_reg_e, sig_mem_to_reg_m, sig_md_start_e, md_dest_e,
        output stall_f, stall_d, flush_d, flush_e, forward_a_d, forward_b_d,
               forward_a_e, forward_b_e, md_busy, md_wb_valid, md_overrun, md_wb_reg
    );

endinterface

// File: rtl/hazard_scoreboard_unit_md_tracker.sv
// Tracks the single outstanding multi-cycle mul/div op: countdown, destination register,
// W-port writeback arbitration and a sticky overrun flag for issues while occupied.
module md_tracker
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  md_start,
    input  logic [REG_ADDR_W-1:0] md_dest_in,
    input  logic                  reg_write_w,
    output logic                  md_busy,
    output logic                  md_wb_valid,
    output logic [REG_ADDR_W-1:0] md_wb_reg,
    output logic                  md_overrun
);

    localparam int              CNT_W    = md_cnt_width(MD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 2);

    md_state_e             state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [REG_ADDR_W-1:0] dest, dest_nxt;
    logic                  overrun, overrun_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MD_IDLE;
            cnt     <= '0;
            dest    <= '0;
            overrun <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dest    <= dest_nxt;
            overrun <= overrun_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nxt   = state;
        cnt_nxt     = cnt;
        dest_nxt    = dest;
        overrun_nxt = overrun | (md_start && (state != MD_IDLE));
        md_wb_valid = 1'b0;
        case (state)
            MD_IDLE: begin
                if (md_start) begin
                    dest_nxt  = md_dest_in;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (cnt == '0) state_nxt = MD_DONE;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            MD_DONE: begin
                // A regular writer already owns the W-port; hold the result one more cycle.
                md_wb_valid = ~reg_write_w;
                if (~reg_write_w) state_nxt = MD_IDLE;
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    assign md_busy    = (state != MD_IDLE);
    assign md_wb_reg  = dest;
    assign md_overrun = overrun;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage pipeline: forwarding selects, load/branch/MD stalls and flushes.
// Define STALL_STATS_EN to add saturating per-term stall-cycle counters (stat_lw/stat_br/stat_md).
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LATENCY = 4
`ifdef STALL_STATS_EN
    , parameter int STAT_W = 32
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    hazard_scoreboard_unit_if.slave hz
`ifdef STALL_STATS_EN
    , output logic [STAT_W-1:0]     stat_lw
    , output logic [STAT_W-1:0]     stat_br
    , output logic [STAT_W-1:0]     stat_md
`endif
);

    typedef logic [REG_ADDR_W-1:0] reg_t;

    // Register 0 is hard-wired, so it never creates a dependency.
    function automatic logic reg_match(input reg_t x, input reg_t r);
        return (x != '0) && (x == r);
    endfunction

    function automatic fwd_sel_e fwd_sel(input reg_t src, input reg_t wr_m, input logic we_m,
                                         input reg_t wr_w, input logic we_w);
        if (we_m && reg_match(src, wr_m)) return FWD_MEM;
        if (we_w && reg_match(src, wr_w)) return FWD_WB;
        return FWD_NONE;
    endfunction

    md_tracker #(
        .REG_ADDR_W (REG_ADDR_W),
        .MD_LATENCY (MD_LATENCY)
    ) u_md_tracker (
        .clk         (clk),
        .reset       (reset),
        .md_start    (hz.sig_md_start_e),
        .md_dest_in  (hz.md_dest_e),
        .reg_write_w (hz.sig_reg_write_w),
        .md_busy     (hz.md_busy),
        .md_wb_valid (hz.md_wb_valid),
        .md_wb_reg   (hz.md_wb_reg),
        .md_overrun  (hz.md_overrun)
    );

    logic branch_or_jr, e_hits_d, m_hits_d;
    logic lw_term, br_term, md_term, stall;

    always_comb begin
        branch_or_jr = hz.sig_branch_d || (hz.sig_jump_d == JUMP_JR);
        // jr only reads rs; a conditional branch compares rs and rt.
        e_hits_d = reg_match(hz.rs_d, hz.write_reg_e)
                || (hz.sig_branch_d && reg_match(hz.rt_d, hz.write_reg_e));
        m_hits_d = reg_match(hz.rs_d, hz.write_reg_m)
                || (hz.sig_branch_d && reg_match(hz.rt_d, hz.write_reg_m));

        lw_term = hz.sig_mem_to_reg_e
               && (reg_match(hz.rs_d, hz.write_reg_e) || reg_match(hz.rt_d, hz.write_reg_e));
        br_term = branch_or_jr
               && ((hz.sig_reg_write_e && e_hits_d) || (hz.sig_mem_to_reg_m && m_hits_d));
        // md_busy doubles as "pending": it stays set through DONE until the writeback cycle.
        md_term = (hz.md_busy && (reg_match(hz.rs_d, hz.md_wb_reg) || reg_match(hz.rt_d, hz.md_wb_reg)))
               || (hz.sig_md_op_d && (hz.md_busy || hz.sig_md_start_e));

        stall = (lw_term || br_term || md_term) && !reset;
    end

    assign hz.stall_f     = stall;
    assign hz.stall_d     = stall;
    assign hz.flush_e     = stall;
    assign hz.flush_d     = hz.branch_taken_d && !stall && !reset;

    assign hz.forward_a_d = hz.sig_reg_write_m && reg_match(hz.rs_d, hz.write_reg_m);
    assign hz.forward_b_d = hz.sig_reg_write_m && reg_match(hz.rt_d, hz.write_reg_m);
    assign hz.forward_a_e = fwd_sel(hz.rs_e, hz.write_reg_m, hz.sig_reg_write_m,
                                    hz.write_reg_w, hz.sig_reg_write_w);
    assign hz.forward_b_e = fwd_sel(hz.rt_e, hz.write_reg_m, hz.sig_reg_write_m,
                                    hz.write_reg_w, hz.sig_reg_write_w);

`ifdef STALL_STATS_EN
    // Terms are counted independently, so one cycle can bump several counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_lw <= '0;
            stat_br <= '0;
            stat_md <= '0;
        end else begin
            if (lw_term && (stat_lw != '1)) stat_lw <= stat_lw + STAT_W'(1);
            if (br_term && (stat_br != '1)) stat_br <= stat_br + STAT_W'(1);
            if (md_term && (stat_md != '1)) stat_md <= stat_md + STAT_W'(1);
        end
    end
`endif

endmodule
